// File: rtl/fifo_serial_pkg.sv
// Shared state encoding and serial line levels for the FIFO-to-serial transmitter.
// Latency: none (declarations only).
// Backpressure: n/a.
package fifo_serial_pkg;

    // FSM state encoding, kept as plain sized constants for legacy tools
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    // Serial line levels
    localparam logic LINE_IDLE = 1'b1;
    localparam logic LVL_START = 1'b0;
    localparam logic LVL_STOP  = 1'b1;

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running, flags the last cycle.
// Latency: bit_end is combinational from the registered count.
// Backpressure: none; clear has priority over run.
module bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end = run && (cnt_q == LAST);

    // Next count: hold at zero when cleared, wrap to zero at the bit boundary
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains a show-ahead FIFO and sends each byte as start/data(LSB first)/[parity]/stop; FIFO_SERIAL_TX_PARITY_EN adds even parity.
// Latency: tx falls one cycle after the fifo_rd cycle; frame is (DATA_W+2[+1])*CLKS_PER_BIT cycles.
// Backpressure: only pops in IDLE when en=1 and the FIFO is non-empty; one idle cycle between frames.
module fifo_serial_tx
    import fifo_serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              take;
    logic              bit_end;
    logic              is_idle;

`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    assign is_idle = (state_q == ST_IDLE);

    // Timer is held at zero in IDLE so the start bit gets a full period
    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (is_idle),
        .run     (!is_idle),
        .bit_end (bit_end)
    );

    // Pop strobe is suppressed while reset is held so the FIFO never loses a byte to reset
    assign fifo_rd = take && !rst;
    assign busy    = !is_idle;
    assign tx_done = (state_q == ST_STOP) && bit_end;

    // Frame sequencing: fetch in IDLE, then step through each bit period on bit_end
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        take    = 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en && !fifo_empty) begin
                    take    = 1'b1;
                    shift_d = fifo_dout;
                    idx_d   = '0;
                    state_d = ST_START;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level follows the registered state so reset forces idle-high at once
    always_comb begin
        tx = LINE_IDLE;
        case (state_q)
            ST_START: tx = LVL_START;
            ST_DATA:  tx = shift_q[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
            ST_PARITY: tx = parity_q;
`endif
            ST_STOP:  tx = LVL_STOP;
            default:  tx = LINE_IDLE;
        endcase
    end

    // State, shift register and bit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

`ifdef FIFO_SERIAL_TX_PARITY_EN
    // Even parity of the byte, captured when it is taken from the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

endmodule
